// File: rtl/execute_stage_if.sv
// ----------------------------------------------------------------------------
// execute_stage_if
//
// Purpose: bundles the operand and result signals of the Y86-64 style execute
// stage so producer and consumer connect through one port.
//
// There is no valid/ready pair on this bus. Every rising clock edge captures
// the operands. The registered results for those operands appear after that
// edge, so the latency is fixed at one cycle and there is no back-pressure.
//
// Signals:
//   icode  [3:0]   instruction code
//   ifun   [3:0]   function code (ALU op or branch/move condition)
//   valC   [63:0]  instruction constant
//   valA   [63:0]  operand A
//   valB   [63:0]  operand B
//   cc     [2:0]   current condition codes {ZF, SF, OF}
//   valE   [63:0]  ALU result (registered)
//   Cnd            condition result (registered)
//   new_cc [2:0]   condition codes produced by this op {ZF, SF, OF} (registered)
//   set_cc         new_cc is to be written to the CC register (registered)
//
// Modports:
//   master : drives operands, observes results (decode side / testbench)
//   slave  : the execute stage itself
// ----------------------------------------------------------------------------
interface execute_stage_if;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [2:0]  cc;
    logic [63:0] valE;
    logic        Cnd;
    logic [2:0]  new_cc;
    logic        set_cc;

    modport master (
        output icode, ifun, valC, valA, valB, cc,
        input  valE, Cnd, new_cc, set_cc
    );

    modport slave (
        input  icode, ifun, valC, valA, valB, cc,
        output valE, Cnd, new_cc, set_cc
    );
endinterface

// File: rtl/execute_stage.sv
// ----------------------------------------------------------------------------
// execute_stage
//
// Purpose: Y86-64 execute stage. It computes the ALU result valE, the
// condition result Cnd for cmovXX/jXX, and the condition codes produced by
// OPq. All outputs are registered. Results for the operands present at a
// rising edge appear after that edge, with no handshake.
//
// Ports:
//   clock    rising-edge clock for every output register
//   reset_n  asynchronous active-low reset; clears all outputs at once
//   bus      execute_stage_if.slave; operands in, registered results out
// ----------------------------------------------------------------------------
module execute_stage (
    input  logic                  clock,
    input  logic                  reset_n,
    execute_stage_if.slave        bus
);

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOV  = 4'h3;
    localparam logic [3:0] I_RMMOV  = 4'h4;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSH   = 4'hA;
    localparam logic [3:0] I_POP    = 4'hB;

    // OPq function codes
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;

    // Condition function codes for cmovXX / jXX
    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [63:0] STACK_STEP = 64'd8;

    // ------------------------------------------------------------------
    // Next-state (combinational) results
    // ------------------------------------------------------------------
    logic [63:0] val_e_next;
    logic        cnd_next;
    logic [2:0]  new_cc_next;
    logic        set_cc_next;

    // OPq datapath. It is kept separate so the flag logic sees the raw ALU
    // result and the selected operation, independent of the icode mux.
    logic [63:0] alu_result;
    logic        alu_valid;
    logic        alu_of;

    always_comb begin
        alu_result = 64'd0;
        alu_valid  = 1'b0;
        alu_of     = 1'b0;
        unique case (bus.ifun)
            ALU_ADD: begin
                alu_result = bus.valB + bus.valA;
                alu_valid  = 1'b1;
                // Same-signed operands that give a result of the other sign
                alu_of     = (bus.valA[63] == bus.valB[63]) &&
                             (alu_result[63] != bus.valB[63]);
            end
            ALU_SUB: begin
                alu_result = bus.valB - bus.valA;
                alu_valid  = 1'b1;
                // Operands of opposite sign where the result's sign departs from valB
                alu_of     = (bus.valA[63] != bus.valB[63]) &&
                             (alu_result[63] != bus.valB[63]);
            end
            ALU_AND: begin
                alu_result = bus.valB & bus.valA;
                alu_valid  = 1'b1;
            end
            ALU_XOR: begin
                alu_result = bus.valB ^ bus.valA;
                alu_valid  = 1'b1;
            end
            default: begin
                // Undefined ALU ops give zero and leave the CC register untouched
                alu_result = 64'd0;
                alu_valid  = 1'b0;
            end
        endcase
    end

    // Condition evaluation uses only the incoming cc, never this op's flags.
    logic zf_in;
    logic sf_in;
    logic of_in;
    logic cond_true;

    assign zf_in = bus.cc[2];
    assign sf_in = bus.cc[1];
    assign of_in = bus.cc[0];

    always_comb begin
        cond_true = 1'b0;
        unique case (bus.ifun)
            C_ALWAYS: cond_true = 1'b1;
            C_LE:     cond_true = (sf_in ^ of_in) | zf_in;
            C_L:      cond_true = sf_in ^ of_in;
            C_E:      cond_true = zf_in;
            C_NE:     cond_true = ~zf_in;
            C_GE:     cond_true = ~(sf_in ^ of_in);
            C_G:      cond_true = ~(sf_in ^ of_in) & ~zf_in;
            default:  cond_true = 1'b0;
        endcase
    end

    // icode mux
    always_comb begin
        val_e_next  = 64'd0;
        cnd_next    = 1'b0;
        set_cc_next = 1'b0;
        unique case (bus.icode)
            I_HALT, I_NOP: begin
                val_e_next = 64'd0;
            end
            I_CMOV: begin
                // valE carries valA whatever the condition; Cnd gates the writeback later
                val_e_next = bus.valA;
                cnd_next   = cond_true;
            end
            I_IRMOV: begin
                val_e_next = bus.valC;
            end
            I_RMMOV, I_MRMOV: begin
                val_e_next = bus.valB + bus.valC;
            end
            I_OPQ: begin
                val_e_next  = alu_result;
                set_cc_next = alu_valid;
            end
            I_JXX: begin
                val_e_next = 64'd0;
                cnd_next   = cond_true;
            end
            I_CALL, I_PUSH: begin
                val_e_next = bus.valB - STACK_STEP;
            end
            I_RET, I_POP: begin
                val_e_next = bus.valB + STACK_STEP;
            end
            default: begin
                val_e_next = 64'd0;
            end
        endcase
    end

    // Flags exist only when they will be written. Otherwise they are forced to 000.
    always_comb begin
        new_cc_next = 3'b000;
        if (set_cc_next) begin
            new_cc_next[2] = (alu_result == 64'd0);
            new_cc_next[1] = alu_result[63];
            new_cc_next[0] = alu_of;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [63:0] val_e_q;
    logic        cnd_q;
    logic [2:0]  new_cc_q;
    logic        set_cc_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            val_e_q  <= 64'd0;
            cnd_q    <= 1'b0;
            new_cc_q <= 3'b000;
            set_cc_q <= 1'b0;
        end else begin
            val_e_q  <= val_e_next;
            cnd_q    <= cnd_next;
            new_cc_q <= new_cc_next;
            set_cc_q <= set_cc_next;
        end
    end

    assign bus.valE   = val_e_q;
    assign bus.Cnd    = cnd_q;
    assign bus.new_cc = new_cc_q;
    assign bus.set_cc = set_cc_q;

endmodule

// File: tb/tb_execute_stage.sv
// ----------------------------------------------------------------------------
// tb_execute_stage
//
// Self-checking bench for execute_stage. It uses a table of directed vectors
// with hand-computed results, plus hand-written sequences for reset and output
// holding. Results are packed as {valE, Cnd, new_cc, set_cc}.
// ----------------------------------------------------------------------------
module tb_execute_stage;

    localparam int RW = 69;

    logic clock;
    logic reset_n;

    execute_stage_if bus ();

    execute_stage dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [2:0]  cc;
        logic [63:0] exp_valE;
        logic        exp_cnd;
        logic [2:0]  exp_new_cc;
        logic        exp_set_cc;
    } vec_t;

    vec_t vecs[$];

    logic [RW-1:0] exp_q[$];
    int passed;
    int total;

    task automatic add(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] valC, input logic [63:0] valA,
                       input logic [63:0] valB, input logic [2:0] cc,
                       input logic [63:0] e, input logic cnd,
                       input logic [2:0] ncc, input logic scc);
        vec_t v;
        v.icode = icode; v.ifun = ifun; v.valC = valC; v.valA = valA;
        v.valB = valB; v.cc = cc; v.exp_valE = e; v.exp_cnd = cnd;
        v.exp_new_cc = ncc; v.exp_set_cc = scc;
        vecs.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input vec_t v);
        bus.icode = v.icode;
        bus.ifun  = v.ifun;
        bus.valC  = v.valC;
        bus.valA  = v.valA;
        bus.valB  = v.valB;
        bus.cc    = v.cc;
    endtask

    function automatic logic [RW-1:0] pack_exp(input vec_t v);
        return {v.exp_valE, v.exp_cnd, v.exp_new_cc, v.exp_set_cc};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [RW-1:0] exp);
        logic [RW-1:0] act;
        act = {bus.valE, bus.Cnd, bus.new_cc, bus.set_cc};
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got valE=%h Cnd=%b new_cc=%b set_cc=%b, expected valE=%h Cnd=%b new_cc=%b set_cc=%b",
                     name, act[68:5], act[4], act[3:1], act[0],
                     exp[68:5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    task automatic check_pop(input string name);
        logic [RW-1:0] exp;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: got empty expected queue, expected an entry", name);
        end else begin
            total--;
            exp = exp_q.pop_front();
            check(name, exp);
        end
    endtask

    // Drive at the falling edge, capture at the rising edge, sample 1 time unit later.
    task automatic run_vec(input vec_t v, input string name);
        @(negedge clock);
        drive(v);
        exp_q.push_back(pack_exp(v));
        @(posedge clock);
        #1;
        check_pop(name);
    endtask

    localparam logic [RW-1:0] ZERO = '0;

    initial begin
        passed = 0;
        total  = 0;

        // Table: icode ifun valC valA valB cc | valE Cnd new_cc set_cc
        add(4'h6, 4'h1, 64'h0, 64'h123, 64'h122, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b010, 1'b1);
        add(4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 3'b000,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b011, 1'b1);
        add(4'h6, 4'h3, 64'h0, 64'h55, 64'h55, 3'b000, 64'h0, 1'b0, 3'b100, 1'b1);
        add(4'h6, 4'h7, 64'h0, 64'h55, 64'h55, 3'b000, 64'h0, 1'b0, 3'b000, 1'b0);
        add(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 3'b010, 64'h0, 1'b1, 3'b000, 1'b0);
        add(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 3'b011, 64'h0, 1'b0, 3'b000, 1'b0);
        add(4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 3'b000, 64'h0, 1'b1, 3'b000, 1'b0);
        add(4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 3'b100, 64'h0, 1'b0, 3'b000, 1'b0);
        add(4'h8, 4'h0, 64'h0, 64'h0, 64'h100, 3'b000, 64'hF8, 1'b0, 3'b000, 1'b0);
        add(4'hB, 4'h0, 64'h0, 64'h0, 64'hF8, 3'b000, 64'h100, 1'b0, 3'b000, 1'b0);
        add(4'h2, 4'h0, 64'h0, 64'hDEAD, 64'h1, 3'b000, 64'hDEAD, 1'b1, 3'b000, 1'b0);
        add(4'h3, 4'h0, 64'h1234_5678, 64'h9, 64'h7, 3'b000, 64'h1234_5678, 1'b0, 3'b000, 1'b0);
        add(4'h4, 4'h0, 64'h8, 64'h0, 64'h10, 3'b000, 64'h18, 1'b0, 3'b000, 1'b0);
        add(4'h5, 4'h0, 64'h2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 64'h1, 1'b0, 3'b000, 1'b0);
        add(4'h6, 4'h2, 64'h0, 64'hF0F0, 64'hFF00, 3'b000, 64'hF000, 1'b0, 3'b000, 1'b1);
        add(4'h6, 4'h1, 64'h0, 64'h1, 64'h8000_0000_0000_0000, 3'b000,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001, 1'b1);
        add(4'h6, 4'h0, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 64'h0, 1'b0, 3'b100, 1'b1);
        add(4'h9, 4'h0, 64'h0, 64'h0, 64'h1000, 3'b000, 64'h1008, 1'b0, 3'b000, 1'b0);
        add(4'hA, 4'h0, 64'h0, 64'h0, 64'h0, 3'b000, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 3'b000, 1'b0);
        add(4'h0, 4'h0, 64'h77, 64'h55, 64'h66, 3'b111, 64'h0, 1'b0, 3'b000, 1'b0);
        add(4'h1, 4'h0, 64'h77, 64'h55, 64'h66, 3'b111, 64'h0, 1'b0, 3'b000, 1'b0);
        add(4'hC, 4'h0, 64'h77, 64'h55, 64'h66, 3'b111, 64'h0, 1'b0, 3'b000, 1'b0);
        add(4'h2, 4'h1, 64'h0, 64'hAB, 64'h0, 3'b001, 64'hAB, 1'b1, 3'b000, 1'b0);
        add(4'h2, 4'h4, 64'h0, 64'hCD, 64'h0, 3'b100, 64'hCD, 1'b0, 3'b000, 1'b0);
        add(4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 3'b011, 64'h0, 1'b1, 3'b000, 1'b0);
        add(4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 3'b100, 64'h0, 1'b1, 3'b000, 1'b0);
        add(4'h7, 4'h8, 64'h0, 64'h0, 64'h0, 3'b111, 64'h0, 1'b0, 3'b000, 1'b0);
        // OPq with a set cc input: Cnd stays 0 and the flags come from the result only
        add(4'h6, 4'h0, 64'h0, 64'h2, 64'h3, 3'b111, 64'h5, 1'b0, 3'b000, 1'b1);

        // Reset held from time 1. Outputs must be zero before any clock edge.
        reset_n = 1'b1;
        drive(vecs[0]);
        #1 reset_n = 1'b0;
        #1 check("reset_immediate", ZERO);

        // A rising edge while reset is low captures nothing
        @(posedge clock);
        #1 check("reset_hold_edge", ZERO);

        @(negedge clock);
        reset_n = 1'b1;
        #1 check("reset_release_no_edge", ZERO);

        // Table sweep, one vector per cycle back to back
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Outputs are registered. Changing the inputs mid-cycle must not disturb them.
        run_vec(vecs[1], "hold_pre");
        @(negedge clock);
        drive(vecs[8]);
        #1 check("hold_mid_cycle", pack_exp(vecs[1]));
        @(posedge clock);
        #1 check("hold_next_edge", pack_exp(vecs[8]));

        // Reset asserted between edges clears the outputs immediately, then capture resumes
        run_vec(vecs[0], "rst_seq_pre");
        #2 reset_n = 1'b0;
        #1 check("rst_seq_immediate", ZERO);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1 check("rst_seq_recover", pack_exp(vecs[0]));

        // A result pending at the time of reset is discarded
        @(negedge clock);
        drive(vecs[18]);
        #1 reset_n = 1'b0;
        @(posedge clock);
        #1 check("rst_discard_pending", ZERO);
        @(negedge clock);
        reset_n = 1'b1;
        drive(vecs[9]);
        @(posedge clock);
        #1 check("rst_discard_recover", pack_exp(vecs[9]));

        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL exp_q_drain: got %0d leftover entries, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
